sparse_bitstream_decoder: RTL and testbench

- Receive-side counterpart of the sparse serializer.
- Samples a framed serial bitmap on a single line, buffers the SIZE-bit frame, then emits the address of every set bit, lowest first, over a valid/ready handshake.
- Pulses done after the last address.
- Sits between the chip-level bitstream pin and downstream address consumers, so addresses serialized by one instance can be reconstructed on the far end.

---
 rtl/sparserdes_pkg.sv | 17 +
 rtl/sparse_prio_enc.sv | 27 ++
 rtl/sparse_bitstream_decoder.sv | 137 +++++++++++++
 tb/tb_sparse_bitstream_decoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sparserdes_pkg.sv
// Shared definitions for the sparse serializer/deserializer pair.
//   state_t    : FSM encoding shared by the serializer and the decoder.
//   addr_width : address width for a bitmap of 'size' channels (min 1 bit).
package sparserdes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int unsigned addr_width(input int unsigned size);
    return (size < 2) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/sparse_prio_enc.sv
// Lowest-set-bit priority encoder, purely combinational.
//   bitmap  : SIZE-bit input vector
//   index   : index of the lowest set bit (0 when bitmap is empty)
//   any_set : at least one bit of bitmap is set
module sparse_prio_enc
  import sparserdes_pkg::*;
#(
  parameter int unsigned SIZE   = 8,
  parameter int unsigned ADDR_W = addr_width(SIZE)
) (
  input  logic [SIZE-1:0]   bitmap,
  output logic [ADDR_W-1:0] index,
  output logic              any_set
);

  always_comb begin
    index   = '0;
    any_set = 1'b0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (bitmap[i] && !any_set) begin
        index   = ADDR_W'(i);
        any_set = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sparse_bitstream_decoder.sv
// Sparse bitstream decoder: samples a framed serial bitmap (start bit 1,
// then SIZE data bits, address 0 first), then presents the address of each
// set bit, lowest first, over a valid/ready handshake, and pulses done once
// the frame has been fully emitted.
//   clk, reset     : clock, synchronous active-high reset
//   enable         : when low every register holds and the line is ignored
//   clear          : clears the sticky overrun flag
//   bitstream_in   : serial input line, idles low
//   addr_out       : current address (holds last value when not valid)
//   addr_valid     : addr_out valid
//   addr_ready     : consumer accepts addr_out
//   done           : one-cycle end-of-frame pulse
//   busy           : FSM not in IDLE
//   overrun        : sticky, start bit seen while emitting / finishing
module sparse_bitstream_decoder
  import sparserdes_pkg::*;
#(
  parameter int unsigned SIZE   = 8,
  parameter int unsigned ADDR_W = addr_width(SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              bitstream_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              done,
  output logic              busy,
  output logic              overrun
);

  state_t              state_q, state_d;
  logic [SIZE-1:0]     bitmap_q, bitmap_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic                overrun_q, overrun_d;

  logic [ADDR_W-1:0]   enc_idx;
  logic                enc_any;
  logic [SIZE-1:0]     recv_map;
  logic [SIZE-1:0]     clr_mask;

  sparse_prio_enc #(
    .SIZE   (SIZE),
    .ADDR_W (ADDR_W)
  ) u_prio_enc (
    .bitmap  (bitmap_q),
    .index   (enc_idx),
    .any_set (enc_any)
  );

  always_comb begin
    state_d   = state_q;
    bitmap_d  = bitmap_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    overrun_d = overrun_q;

    // Bitmap with the currently sampled data bit merged in; lets the last
    // data bit decide between EMIT and DONE in the same cycle it arrives.
    recv_map          = bitmap_q;
    recv_map[cnt_q]   = bitstream_in;

    clr_mask          = '0;
    clr_mask[enc_idx] = 1'b1;

    if (enable) begin
      if (clear) begin
        overrun_d = 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (bitstream_in) begin
            state_d = RECV;
            cnt_d   = '0;
          end
        end
        RECV: begin
          bitmap_d = recv_map;
          if (cnt_q == ADDR_W'(SIZE - 1)) begin
            state_d = (|recv_map) ? EMIT : DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        EMIT: begin
          // Set after the clear so a coincident new overrun wins.
          if (bitstream_in) begin
            overrun_d = 1'b1;
          end
          // Remember the presented address so addr_out holds it afterwards.
          last_d = enc_idx;
          if (addr_ready) begin
            bitmap_d = bitmap_q & ~clr_mask;
            if (bitmap_d == '0) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (bitstream_in) begin
            overrun_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bitmap_q  <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitmap_q  <= bitmap_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    addr_valid = (state_q == EMIT) && enc_any;
    addr_out   = addr_valid ? enc_idx : last_q;
    done       = (state_q == DONE);
    busy       = (state_q != IDLE);
    overrun    = overrun_q;
  end

endmodule

// File: tb/tb_sparse_bitstream_decoder.sv
module tb_sparse_bitstream_decoder;

  logic       clk = 1'b0;
  logic       reset, enable, clear, bitstream_in, addr_ready;
  logic [2:0] addr_out;
  logic       addr_valid, done, busy, overrun;

  int tests = 0;
  int fails = 0;

  sparse_bitstream_decoder #(.SIZE(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .bitstream_in (bitstream_in),
    .addr_out     (addr_out),
    .addr_valid   (addr_valid),
    .addr_ready   (addr_ready),
    .done         (done),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       in;
    logic       rdy;
    logic       en;
    logic       exp_valid;
    logic [2:0] exp_addr;
    logic       exp_done;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic in, input logic rdy, input logic en,
                     input logic v, input logic [2:0] a, input logic d,
                     input logic b);
    vec_t r;
    r.in = in; r.rdy = rdy; r.en = en;
    r.exp_valid = v; r.exp_addr = a; r.exp_done = d; r.exp_busy = b;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] map);
    bitstream_in = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      bitstream_in = map[i];
      tick();
    end
    bitstream_in = 1'b0;
  endtask

  task automatic chk_addr(input string name, input logic [2:0] a);
    chk({name, "_valid"}, int'(addr_valid), 1);
    chk({name, "_addr"}, int'(addr_out), int'(a));
  endtask

  initial begin
    logic [7:0] fa;
    logic [2:0] exp3 [3];
    exp3[0] = 3'd1; exp3[1] = 3'd4; exp3[2] = 3'd7;
    fa = 8'h92;

    reset = 1'b1; enable = 1'b1; clear = 1'b0;
    bitstream_in = 1'b1; addr_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", int'(addr_valid), 0);
    chk("rst_addr", int'(addr_out), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;
    bitstream_in = 1'b0;

    // Frame 0x92 (addresses 1,4,7), ready always high.
    add(1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(fa[i], 1, 1, 0, 0, 0, 1);
    add(0, 1, 1, 1, 1, 0, 1);
    add(0, 1, 1, 1, 4, 0, 1);
    add(0, 1, 1, 1, 7, 0, 1);
    add(0, 1, 1, 0, 7, 1, 1);
    add(0, 1, 1, 0, 7, 0, 0);
    // Empty frame: done at t+9 only.
    add(1, 1, 1, 0, 7, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 1, 0, 7, 0, 1);
    add(0, 1, 1, 0, 7, 1, 1);
    add(0, 1, 1, 0, 7, 0, 0);
    // Full frame with enable low for two cycles mid-emission.
    add(1, 1, 1, 0, 7, 0, 0);
    for (int i = 0; i < 8; i++) add(1, 1, 1, 0, 7, 0, 1);
    add(0, 1, 1, 1, 0, 0, 1);
    add(0, 1, 1, 1, 1, 0, 1);
    add(0, 1, 0, 1, 2, 0, 1);
    add(0, 1, 0, 1, 2, 0, 1);
    add(0, 1, 1, 1, 2, 0, 1);
    add(0, 1, 1, 1, 3, 0, 1);
    add(0, 1, 1, 1, 4, 0, 1);
    add(0, 1, 1, 1, 5, 0, 1);
    add(0, 1, 1, 1, 6, 0, 1);
    add(0, 1, 1, 1, 7, 0, 1);
    add(0, 1, 1, 0, 7, 1, 1);
    add(0, 1, 1, 0, 7, 0, 0);

    foreach (vecs[k]) begin
      bitstream_in = vecs[k].in;
      addr_ready   = vecs[k].rdy;
      enable       = vecs[k].en;
      chk($sformatf("vec%0d_valid", k), int'(addr_valid), int'(vecs[k].exp_valid));
      chk($sformatf("vec%0d_addr", k),  int'(addr_out),   int'(vecs[k].exp_addr));
      chk($sformatf("vec%0d_done", k),  int'(done),       int'(vecs[k].exp_done));
      chk($sformatf("vec%0d_busy", k),  int'(busy),       int'(vecs[k].exp_busy));
      tick();
    end
    bitstream_in = 1'b0; enable = 1'b1; addr_ready = 1'b1;

    // Back-pressure: ready low for 3 cycles at each address.
    send_frame(fa);
    for (int a = 0; a < 3; a++) begin
      for (int j = 0; j < 4; j++) begin
        addr_ready = (j == 3);
        chk_addr($sformatf("stall_a%0d_c%0d", a, j), exp3[a]);
        chk($sformatf("stall_a%0d_c%0d_done", a, j), int'(done), 0);
        tick();
      end
    end
    addr_ready = 1'b1;
    chk("stall_done", int'(done), 1);
    chk("stall_done_valid", int'(addr_valid), 0);
    tick();
    chk("stall_done_once", int'(done), 0);
    chk("stall_idle", int'(busy), 0);

    // Start bit during emission sets overrun; frame still completes.
    send_frame(fa);
    bitstream_in = 1'b1;
    chk_addr("ovr_a0", 3'd1);
    tick();
    bitstream_in = 1'b0;
    chk("ovr_set", int'(overrun), 1);
    chk_addr("ovr_a1", 3'd4);
    tick();
    chk_addr("ovr_a2", 3'd7);
    tick();
    chk("ovr_done", int'(done), 1);
    tick();
    chk("ovr_idle", int'(busy), 0);
    chk("ovr_sticky", int'(overrun), 1);
    tick();
    chk("ovr_sticky2", int'(overrun), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("ovr_cleared", int'(overrun), 0);

    // Reset during emission after address 1 is accepted.
    send_frame(8'hFF);
    chk_addr("rmid_a0", 3'd0);
    tick();
    chk_addr("rmid_a1", 3'd1);
    tick();
    chk_addr("rmid_a2", 3'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmid_valid", int'(addr_valid), 0);
    chk("rmid_addr", int'(addr_out), 0);
    chk("rmid_done", int'(done), 0);
    chk("rmid_busy", int'(busy), 0);
    chk("rmid_overrun", int'(overrun), 0);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("rmid_nodone%0d", j), int'(done), 0);
      chk($sformatf("rmid_idle%0d", j), int'(busy), 0);
    end
    send_frame(fa);
    for (int a = 0; a < 3; a++) begin
      chk_addr($sformatf("post_a%0d", a), exp3[a]);
      tick();
    end
    chk("post_done", int'(done), 1);
    tick();
    chk("post_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
